// File: rtl/common_types_pkg.sv
// Shared types for the pipeline control blocks: stage indices, register
// address type and the stall-cause encoding used by hazard_ctrl.
package common_types_pkg;

    localparam int STG_F2D = 0;
    localparam int STG_D2E = 1;
    localparam int STG_E2M = 2;
    localparam int STG_M2W = 3;

    localparam int REG_AW = 5;
    typedef logic [REG_AW-1:0] regaddr_t;

    // Ordered by priority; the first active cause decides the stall action.
    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_HALT_DMISS,
        CAUSE_IMISS_IDLE,
        CAUSE_IMISS,
        CAUSE_LOAD_USE,
        CAUSE_SCOREBOARD,
        CAUSE_LONG_BUSY
    } stall_cause_e;

    function automatic logic cause_holds_all(input stall_cause_e c);
        return (c == CAUSE_HALT_DMISS) || (c == CAUSE_IMISS_IDLE);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for long-op destinations. A set in the same
// cycle as a clear of the same register wins; register 0 is never pending.
module hazard_scoreboard #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    output logic              busy_rs1,
    output logic              busy_rs2,
    output logic              busy_rd
);

    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_en) begin
            sb_d[clr_rd] = 1'b0;
        end
        // Applied after the clear: the issuing op is younger than the retiring one.
        if (set_en && (set_rd != '0)) begin
            sb_d[set_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign busy_rs1 = sb_q[rs1];
    assign busy_rs2 = sb_q[rs2];
    assign busy_rd  = sb_q[rd];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage enables/flushes, long-op scoreboard,
// latched redirect and saturating stall/flush counters.
module hazard_ctrl
    import common_types_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dread,
    input  logic              dwrite,
    input  logic              branch,
    input  logic              d2e_dread,
    input  logic [REG_AW-1:0] d2e_rd,
    input  logic [REG_AW-1:0] f2d_rs1,
    input  logic [REG_AW-1:0] f2d_rs2,
    input  logic [REG_AW-1:0] f2d_rd,
    input  logic              f2d_long,
    input  logic              lu_issue,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic              lu_busy,
    input  logic              lu_done,
    input  logic [REG_AW-1:0] lu_done_rd,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_flush,
    output logic              branch_pending,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    stall_cause_e cause;
    logic         redirect;
    logic         redirect_req;
    logic         hold_all;
    logic         service;
    logic         load_use;
    logic         sb_hit;
    logic         busy_rs1;
    logic         busy_rs2;
    logic         busy_rd;
    logic         pending_d;

    assign redirect     = branch | branch_pending;
    assign redirect_req = redirect & ihit;

    hazard_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (lu_issue & ~redirect_req),
        .set_rd   (lu_rd),
        .clr_en   (lu_done),
        .clr_rd   (lu_done_rd),
        .rs1      (f2d_rs1),
        .rs2      (f2d_rs2),
        .rd       (f2d_rd),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_rd  (busy_rd)
    );

    assign load_use = d2e_dread && (d2e_rd != '0) &&
                      ((d2e_rd == f2d_rs1) || (d2e_rd == f2d_rs2));
    assign sb_hit   = busy_rs1 | busy_rs2 | busy_rd;

    always_comb begin
        cause = CAUSE_NONE;
        if (halt || ((dwrite || dread) && !dhit)) begin
            cause = CAUSE_HALT_DMISS;
        end else if (!dread && !dwrite && !ihit) begin
            cause = CAUSE_IMISS_IDLE;
        end else if (!redirect) begin
            if (!ihit) begin
                cause = CAUSE_IMISS;
            end else if (load_use) begin
                cause = CAUSE_LOAD_USE;
            end else if (sb_hit) begin
                cause = CAUSE_SCOREBOARD;
            end else if (f2d_long && lu_busy) begin
                cause = CAUSE_LONG_BUSY;
            end
        end
    end

    assign hold_all = cause_holds_all(cause);
    // A redirect is only acted on once nothing is freezing the whole pipe.
    assign service  = redirect_req & ~hold_all;

    always_comb begin
        stage_en    = '1;
        stage_flush = '0;
        case (cause)
            CAUSE_HALT_DMISS,
            CAUSE_IMISS_IDLE: begin
                stage_en = '0;
            end
            CAUSE_IMISS,
            CAUSE_LOAD_USE,
            CAUSE_SCOREBOARD,
            CAUSE_LONG_BUSY: begin
                stage_en[STG_F2D]    = 1'b0;
                stage_en[STG_D2E]    = 1'b0;
                stage_flush[STG_D2E] = 1'b1;
            end
            default: begin
                stage_en    = '1;
                stage_flush = '0;
            end
        endcase
        if (service) begin
            stage_en                = '1;
            stage_flush[STG_F2D]    = 1'b1;
            stage_flush[STG_D2E]    = 1'b1;
            stage_flush[STG_E2M]    = 1'b1;
        end
    end

    // Any redirect not serviced this cycle is remembered until it is.
    always_comb begin
        pending_d = branch_pending;
        if (service) begin
            pending_d = 1'b0;
        end else if (branch) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_pending <= 1'b0;
        end else begin
            branch_pending <= pending_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!stage_en[STG_F2D] && !halt && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (service && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

    localparam int STAGES = 4;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              halt;
    logic              ihit;
    logic              dhit;
    logic              dread;
    logic              dwrite;
    logic              branch;
    logic              d2e_dread;
    logic [REG_AW-1:0] d2e_rd;
    logic [REG_AW-1:0] f2d_rs1;
    logic [REG_AW-1:0] f2d_rs2;
    logic [REG_AW-1:0] f2d_rd;
    logic              f2d_long;
    logic              lu_issue;
    logic [REG_AW-1:0] lu_rd;
    logic              lu_busy;
    logic              lu_done;
    logic [REG_AW-1:0] lu_done_rd;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_flush;
    logic              branch_pending;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    int checks;
    int errors;

    hazard_ctrl #(
        .STAGES (STAGES),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .ihit           (ihit),
        .dhit           (dhit),
        .dread          (dread),
        .dwrite         (dwrite),
        .branch         (branch),
        .d2e_dread      (d2e_dread),
        .d2e_rd         (d2e_rd),
        .f2d_rs1        (f2d_rs1),
        .f2d_rs2        (f2d_rs2),
        .f2d_rd         (f2d_rd),
        .f2d_long       (f2d_long),
        .lu_issue       (lu_issue),
        .lu_rd          (lu_rd),
        .lu_busy        (lu_busy),
        .lu_done        (lu_done),
        .lu_done_rd     (lu_done_rd),
        .stage_en       (stage_en),
        .stage_flush    (stage_flush),
        .branch_pending (branch_pending),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        halt       = 1'b0;
        ihit       = 1'b1;
        dhit       = 1'b0;
        dread      = 1'b0;
        dwrite     = 1'b0;
        branch     = 1'b0;
        d2e_dread  = 1'b0;
        d2e_rd     = '0;
        f2d_rs1    = '0;
        f2d_rs2    = '0;
        f2d_rd     = '0;
        f2d_long   = 1'b0;
        lu_issue   = 1'b0;
        lu_rd      = '0;
        lu_busy    = 1'b0;
        lu_done    = 1'b0;
        lu_done_rd = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b1;
        #1;
        check("rst_en", 32'(stage_en), 32'hf);
        check("rst_flush", 32'(stage_flush), 32'h0);
        check("rst_pending", 32'(branch_pending), 32'h0);
        check("rst_stall", 32'(stall_cycles), 32'h0);
        check("rst_flushcnt", 32'(flush_count), 32'h0);
        #1 rst = 1'b0;
        tick();

        // load-use on rs2
        d2e_dread = 1'b1; d2e_rd = 5'd5; f2d_rs2 = 5'd5;
        #1;
        check("lu_en", 32'(stage_en), 32'hc);
        check("lu_flush", 32'(stage_flush), 32'h2);
        check("lu_stall0", 32'(stall_cycles), 32'h0);
        tick();
        check("lu_stall1", 32'(stall_cycles), 32'h1);
        d2e_rd = 5'd0;
        #1;
        check("lu_r0_en", 32'(stage_en), 32'hf);
        check("lu_r0_flush", 32'(stage_flush), 32'h0);
        tick();
        check("lu_r0_stall", 32'(stall_cycles), 32'h1);

        // scoreboard RAW on r7
        idle();
        lu_issue = 1'b1; lu_rd = 5'd7;
        #1;
        check("sb_issue_en", 32'(stage_en), 32'hf);
        tick();
        lu_issue = 1'b0; f2d_rs1 = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sb_hold_en", 32'(stage_en), 32'hc);
            tick();
        end
        lu_done = 1'b1; lu_done_rd = 5'd7;
        #1;
        check("sb_done_en", 32'(stage_en), 32'hc);
        tick();
        lu_done = 1'b0;
        #1;
        check("sb_clear_en", 32'(stage_en), 32'hf);
        check("sb_stall", 32'(stall_cycles), 32'h5);

        // same-cycle set and clear of r7: set wins
        f2d_rs1 = 5'd0;
        lu_issue = 1'b1; lu_rd = 5'd7; lu_done = 1'b1; lu_done_rd = 5'd7;
        tick();
        lu_issue = 1'b0; lu_done = 1'b0; f2d_rs1 = 5'd7;
        #1;
        check("sb_setwins_en", 32'(stage_en), 32'hc);
        lu_done = 1'b1;
        tick();
        lu_done = 1'b0;
        #1;
        check("sb_setwins_clr", 32'(stage_en), 32'hf);

        // branch pulse during I-miss with a completed load in MEM
        idle();
        ihit = 1'b0; dread = 1'b1; dhit = 1'b1; branch = 1'b1;
        #1;
        check("br_c0_en", 32'(stage_en), 32'hf);
        check("br_c0_flush", 32'(stage_flush), 32'h0);
        check("br_c0_pend", 32'(branch_pending), 32'h0);
        tick();
        branch = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("br_pend", 32'(branch_pending), 32'h1);
            check("br_miss_flush", 32'(stage_flush), 32'h0);
            tick();
        end
        ihit = 1'b1;
        #1;
        check("br_srv_flush", 32'(stage_flush), 32'h7);
        check("br_srv_en", 32'(stage_en), 32'hf);
        check("br_srv_cnt0", 32'(flush_count), 32'h0);
        tick();
        check("br_after_pend", 32'(branch_pending), 32'h0);
        check("br_after_cnt", 32'(flush_count), 32'h1);
        check("br_after_flush", 32'(stage_flush), 32'h0);
        check("br_stall", 32'(stall_cycles), 32'h6);

        // redirect kills the long-op issued alongside it
        idle();
        branch = 1'b1; lu_issue = 1'b1; lu_rd = 5'd9;
        #1;
        check("kill_flush", 32'(stage_flush), 32'h7);
        tick();
        idle();
        f2d_rs1 = 5'd9;
        #1;
        check("kill_sb_en", 32'(stage_en), 32'hf);
        check("kill_cnt", 32'(flush_count), 32'h2);

        // long-unit structural stall
        idle();
        f2d_long = 1'b1; lu_busy = 1'b1;
        #1;
        check("long_en", 32'(stage_en), 32'hc);
        check("long_flush", 32'(stage_flush), 32'h2);
        tick();

        // D-miss beats load-use; reset mid-stall clears state at once
        idle();
        lu_issue = 1'b1; lu_rd = 5'd3;
        tick();
        idle();
        dwrite = 1'b1; dhit = 1'b0; ihit = 1'b0; branch = 1'b1;
        d2e_dread = 1'b1; d2e_rd = 5'd5; f2d_rs2 = 5'd5;
        #1;
        check("dm_en", 32'(stage_en), 32'h0);
        check("dm_flush", 32'(stage_flush), 32'h0);
        tick();
        branch = 1'b0;
        #1;
        check("dm_pend", 32'(branch_pending), 32'h1);
        check("dm_en2", 32'(stage_en), 32'h0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_pend", 32'(branch_pending), 32'h0);
        check("rst_mid_stall", 32'(stall_cycles), 32'h0);
        check("rst_mid_flushcnt", 32'(flush_count), 32'h0);
        idle();
        f2d_rs1 = 5'd3;
        #1;
        check("rst_mid_sb", 32'(stage_en), 32'hf);
        rst = 1'b0;
        tick();

        // halted cycles are not counted as stalls
        halt = 1'b1;
        #1;
        check("halt_en", 32'(stage_en), 32'h0);
        tick();
        halt = 1'b0;
        check("halt_stall", 32'(stall_cycles), 32'h0);

        // counter saturation: idle I-miss stalls everything
        idle();
        ihit = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("sat_15", 32'(stall_cycles), 32'hf);
        for (int i = 0; i < 5; i++) tick();
        check("sat_20", 32'(stall_cycles), 32'hf);
        check("sat_en", 32'(stage_en), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised, stateful successor to the combinational pipeline hazard unit.
- Generates per-stage enable and flush vectors for an N-register in-order pipeline.
- Adds three stateful features:
  - a register scoreboard for a variable-latency long-op unit (divide/multi-cycle multiply);
  - a latched pending-branch flush, so a branch pulse that arrives during an I-miss is not lost;
  - saturating stall and flush performance counters.
- Sits beside the pipeline registers and drives every `*_en` / `*_flush` input.

Parameters:
- STAGES, 4: number of inter-stage registers. Index 0=f2d, 1=d2e, 2=e2m, 3=m2w; indices >=4 are extra back-end registers. Legal range >=4.
- REG_AW, 5: register-address width. The scoreboard holds 2**REG_AW bits.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- halt  in  1  core halted
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- dread  in  1  MEM-stage load request
- dwrite  in  1  MEM-stage store request
- branch  in  1  MEM-stage redirect (may be a single-cycle pulse)
- d2e_dread  in  1  instruction in EX is a load
- d2e_rd  in  REG_AW  EX destination register
- f2d_rs1  in  REG_AW  decode source register 1
- f2d_rs2  in  REG_AW  decode source register 2
- f2d_rd  in  REG_AW  decode destination register
- f2d_long  in  1  decode instruction is a long-op
- lu_issue  in  1  EX hands a long-op to the unit this cycle
- lu_rd  in  REG_AW  destination register of the issued long-op
- lu_busy  in  1  long-op unit cannot accept a new op
- lu_done  in  1  long-op result written back this cycle
- lu_done_rd  in  REG_AW  register written by lu_done
- stage_en  out  STAGES  per-register enable
- stage_flush  out  STAGES  per-register flush (bubble insert)
- branch_pending  out  1  latched, unserviced redirect
- stall_cycles  out  CNT_W  count of cycles in which stage_en[0]=0 and halt=0
- flush_count  out  CNT_W  count of branch flushes serviced

Behaviour:
- Reset (async, any cycle, including mid-stall):
  - scoreboard cleared, branch_pending=0, both counters=0.
  - Combinational outputs follow the cleared state: stage_en all 1, stage_flush all 0 unless the inputs request otherwise.
- Defaults: stage_en all 1, stage_flush all 0.
- Stall priority (first match wins):
  1. halt, or (dwrite|dread)&~dhit: all stage_en=0.
  2. ~dread&~dwrite&~ihit: all stage_en=0.
  3. ~ihit & ~redirect: en[0]=en[1]=0, flush[1]=1.
  4. Load-use, when d2e_dread & ~redirect & d2e_rd!=0 & (d2e_rd==f2d_rs1 | d2e_rd==f2d_rs2): en[0]=en[1]=0, flush[1]=1.
  5. Scoreboard RAW/WAW, when ~redirect and any of sb[f2d_rs1], sb[f2d_rs2], sb[f2d_rd] is set (register 0 never set): same action as item 4.
  6. Long-unit structural, when f2d_long & lu_busy & ~redirect: same action as item 4.
- Redirect:
  - redirect = branch | branch_pending.
  - When redirect & ihit, flush[0..2]=1. This overrides items 3–6 and the cleared enable states, and increments flush_count. Items 1–2 still hold their enables at 0.
  - Because items 1–2 still hold enables, the flush is serviced only when no item 1/2 stall is active. Until then, branch_pending remains set.
- branch_pending:
  - Sets on branch & ~ihit.
  - Clears on the cycle a redirect flush is serviced.
  - Set and service in the same cycle cannot occur; service requires ihit.
- Scoreboard update (registered):
  - Set bit lu_rd on lu_issue & lu_rd!=0 & ~(redirect&ihit). The suppression covers the EX op killed by the flush.
  - Clear bit lu_done_rd on lu_done.
  - Same register set and cleared in the same cycle: set wins, because the new issue is the younger op.
  - A done for a register that is not pending is a no-op.
- Counters:
  - stall_cycles increments when en[0]==0 & ~halt.
  - flush_count increments per serviced flush.
  - Both saturate at all-ones and never wrap.
- Latency:
  - All stall and flush outputs are combinational from the inputs and the current state.
  - State takes effect one cycle after the triggering edge.

Decomposition:
- Shared package common_types_pkg gains:
  - stage index constants (STG_F2D=0, STG_D2E=1, STG_E2M=2, STG_M2W=3);
  - a `regaddr_t` typedef sized by REG_AW.
- One sub-module: hazard_scoreboard. It holds the 2**REG_AW-bit vector, the set/clear logic with set-wins priority, and a three-port read (rs1, rs2, rd).
- Counters and branch latch stay in the top level.

Test Plan:
- Load-use:
  - Stimulus: ihit=1, d2e_dread=1, d2e_rd=5, f2d_rs2=5.
  - Required: stage_en=4'b1100, stage_flush=4'b0010, stall_cycles 0->1.
  - Also required: repeating with d2e_rd=0 gives no stall.
- Scoreboard:
  - Stimulus: lu_issue with lu_rd=7; next cycle f2d_rs1=7.
  - Required: stall held until the cycle lu_done with lu_done_rd=7; the cycle after, stage_en=4'b1111.
  - Also required: same-cycle lu_issue(rd=7) + lu_done(rd=7) leaves sb[7]=1.
- Branch pulse during I-miss:
  - Stimulus: branch=1 for one cycle with ihit=0, dread=1, dhit=1; three cycles later ihit=1.
  - Required: branch_pending=1 for those cycles; stage_flush=4'b0111 on the ihit cycle; flush_count=1; branch_pending=0 next cycle.
- Flush kills issue:
  - Stimulus: branch=1, ihit=1, lu_issue=1, lu_rd=9.
  - Required: sb[9] stays 0; flush_count increments.
- D-miss priority:
  - Stimulus: dwrite=1, dhit=0, load-use condition also true.
  - Required: stage_en=0000, stage_flush=0000.
  - Also required: asserting rst mid-stall clears the scoreboard, branch_pending and counters immediately (before the next clk edge).
- Saturation (CNT_W=4):
  - Stimulus: 20 consecutive stall cycles.
  - Required: stall_cycles holds 15.
